// File: rtl/axi_stream_write_arbiter.sv
// ----------------------------------------------------------------------------
// axi_stream_write_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one AXI-stream master port between
//   NUM_REQ AXI-stream requesters. A grant is held for a whole packet (up to
//   and including the tlast beat). With LOCK_PACKETS=0 the grant is held for
//   a single beat instead. The master side is a registered output stage, and
//   o_m_tid carries the index of the requester that sourced each beat.
//
// Ports:
//   i_clk        in   1                  clock, rising edge
//   i_aresetn    in   1                  asynchronous active-low reset
//   i_s_tvalid   in   NUM_REQ            per-requester valid
//   o_s_tready   out  NUM_REQ            per-requester ready (one-hot or zero)
//   i_s_tdata    in   NUM_REQ*BUS_WIDTH  requester k data at [k*BUS_WIDTH +: BUS_WIDTH]
//   i_s_tlast    in   NUM_REQ            per-requester end-of-packet
//   o_m_tvalid   out  1                  master valid (registered)
//   i_m_tready   in   1                  master ready from the sink
//   o_m_tdata    out  BUS_WIDTH          master data (registered)
//   o_m_tlast    out  1                  master end-of-packet (registered)
//   o_m_tid      out  ID_WIDTH           source index of the current master beat
//   o_busy       out  1                  a grant is open or a beat is pending
// ----------------------------------------------------------------------------
module axi_stream_write_arbiter #(
  parameter int BUS_WIDTH    = 16,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int LOCK_PACKETS = 1
) (
  input  logic                         i_clk,
  input  logic                         i_aresetn,
  input  logic [NUM_REQ-1:0]           i_s_tvalid,
  output logic [NUM_REQ-1:0]           o_s_tready,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] i_s_tdata,
  input  logic [NUM_REQ-1:0]           i_s_tlast,
  output logic                         o_m_tvalid,
  input  logic                         i_m_tready,
  output logic [BUS_WIDTH-1:0]         o_m_tdata,
  output logic                         o_m_tlast,
  output logic [ID_WIDTH-1:0]          o_m_tid,
  output logic                         o_busy
);

  // Requester vectors are padded to the full ID range so that indexing by an
  // ID_WIDTH-bit grant never leaves the array, whatever NUM_REQ is.
  localparam int NUM_SLOTS = 1 << ID_WIDTH;
  // One extra bit so ptr + offset can be formed before the modulo wrap.
  localparam int PW = ID_WIDTH + 1;
  localparam logic REARB_EVERY_BEAT = (LOCK_PACKETS == 0);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t                state_reg;
  logic [ID_WIDTH-1:0]   ptr_reg;
  logic [ID_WIDTH-1:0]   grant_reg;

  logic                  m_tvalid_reg;
  logic [BUS_WIDTH-1:0]  m_tdata_reg;
  logic                  m_tlast_reg;
  logic [ID_WIDTH-1:0]   m_tid_reg;

  logic [NUM_SLOTS-1:0]  valid_pad;
  logic [NUM_SLOTS-1:0]  last_pad;
  logic [BUS_WIDTH-1:0]  data_pad [NUM_SLOTS];

  logic                  found_next;
  logic [ID_WIDTH-1:0]   winner_next;
  logic [PW-1:0]         scan_idx;
  logic [ID_WIDTH-1:0]   ptr_next;

  logic                  out_ready;
  logic                  accept;
  logic                  end_grant;

  // --------------------------------------------------------------------------
  // Unpack / pad requester inputs
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_real
        assign valid_pad[gi] = i_s_tvalid[gi];
        assign last_pad[gi]  = i_s_tlast[gi];
        assign data_pad[gi]  = i_s_tdata[gi*BUS_WIDTH +: BUS_WIDTH];
      end else begin : g_unused
        assign valid_pad[gi] = 1'b0;
        assign last_pad[gi]  = 1'b0;
        assign data_pad[gi]  = '0;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester scanning from ptr_reg upward,
  // wrapping at NUM_REQ (which need not be a power of two).
  // --------------------------------------------------------------------------
  always_comb begin
    found_next  = 1'b0;
    winner_next = ptr_reg;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr_reg} + PW'(i);
      if (scan_idx >= PW'(NUM_REQ)) begin
        scan_idx = scan_idx - PW'(NUM_REQ);
      end
      if (!found_next && valid_pad[scan_idx[ID_WIDTH-1:0]]) begin
        found_next  = 1'b1;
        winner_next = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  // Priority moves to the requester just after the one that finished.
  always_comb begin
    if (grant_reg == ID_WIDTH'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_reg + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // The output register can take a new beat when it is empty or being
  // drained this cycle; this is what lets a grant stream one beat per cycle.
  assign out_ready = !m_tvalid_reg || i_m_tready;
  assign accept    = (state_reg == S_GRANT) && valid_pad[grant_reg] && out_ready;
  assign end_grant = accept && (last_pad[grant_reg] || REARB_EVERY_BEAT);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign o_s_tready[gi] = (state_reg == S_GRANT) &&
                              (grant_reg == ID_WIDTH'(gi)) && out_ready;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration FSM and registered master output stage
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tlast_reg  <= 1'b0;
      m_tid_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // tdata/tlast are deliberately ignored here; only tvalid competes.
          if (found_next) begin
            grant_reg <= winner_next;
            state_reg <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A requester that drops tvalid mid-packet simply stalls the grant.
          if (end_grant) begin
            ptr_reg   <= ptr_next;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase

      if (accept) begin
        m_tvalid_reg <= 1'b1;
        m_tdata_reg  <= data_pad[grant_reg];
        m_tlast_reg  <= last_pad[grant_reg];
        m_tid_reg    <= grant_reg;
      end else if (i_m_tready) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

  assign o_m_tvalid = m_tvalid_reg;
  assign o_m_tdata  = m_tdata_reg;
  assign o_m_tlast  = m_tlast_reg;
  assign o_m_tid    = m_tid_reg;
  assign o_busy     = (state_reg == S_GRANT) || m_tvalid_reg;

endmodule

// File: tb/tb_axi_stream_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_stream_write_arbiter
//
// Purpose:
//   Self-checking bench for axi_stream_write_arbiter. Each requester is fed
//   from its own beat queue; the expected master beat order is pushed to a
//   scoreboard queue as stimulus is set up and popped on every master
//   handshake. Directed scenarios cover latency, round-robin order and wrap,
//   packet locking, sink backpressure and reset in the middle of a packet.
// ----------------------------------------------------------------------------
module tb_axi_stream_write_arbiter;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             i_clk = 1'b0;
  logic             i_aresetn;
  logic [N-1:0]     i_s_tvalid;
  logic [N-1:0]     o_s_tready;
  logic [N*W-1:0]   i_s_tdata;
  logic [N-1:0]     i_s_tlast;
  logic             o_m_tvalid;
  logic             i_m_tready;
  logic [W-1:0]     o_m_tdata;
  logic             o_m_tlast;
  logic [IDW-1:0]   o_m_tid;
  logic             o_busy;

  always #5 i_clk = ~i_clk;

  axi_stream_write_arbiter #(
    .BUS_WIDTH   (W),
    .NUM_REQ     (N),
    .ID_WIDTH    (IDW),
    .LOCK_PACKETS(1)
  ) dut (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_s_tvalid(i_s_tvalid),
    .o_s_tready(o_s_tready),
    .i_s_tdata (i_s_tdata),
    .i_s_tlast (i_s_tlast),
    .o_m_tvalid(o_m_tvalid),
    .i_m_tready(i_m_tready),
    .o_m_tdata (o_m_tdata),
    .o_m_tlast (o_m_tlast),
    .o_m_tid   (o_m_tid),
    .o_busy    (o_busy)
  );

  // Source beat queues: {tlast, tdata}
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic [16:0] q3[$];
  // Scoreboard: {13'b0, tid, tlast, tdata}
  logic [31:0] exp_q[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int cycle      = 0;
  int gap_exp    = 0;
  bit first_beat = 1'b1;
  int prev_cyc   = 0;
  int beats_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  task automatic push_src(input int k, input logic [15:0] d, input logic l);
    case (k)
      0: q0.push_back({l, d});
      1: q1.push_back({l, d});
      2: q2.push_back({l, d});
      default: q3.push_back({l, d});
    endcase
  endtask

  task automatic push_exp(input int k, input logic [15:0] d, input logic l);
    logic [1:0] tid;
    tid = k[1:0];
    exp_q.push_back({13'd0, tid, l, d});
  endtask

  task automatic push_both(input int k, input logic [15:0] d, input logic l);
    push_src(k, d, l);
    push_exp(k, d, l);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
          q2.size() == 0 && q3.size() == 0 && !o_m_tvalid) break;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Source driver and master monitor. Handshakes are sampled on the falling
  // edge; sources advance 1 ns after the rising edge that consumed a beat.
  initial begin : bfm
    logic [N-1:0] took;
    logic [31:0]  obs;
    logic [31:0]  e;
    i_s_tvalid = '0;
    i_s_tdata  = '0;
    i_s_tlast  = '0;
    forever begin
      @(negedge i_clk);
      took = i_s_tvalid & o_s_tready;
      if (o_m_tvalid && i_m_tready) begin
        obs = {13'd0, o_m_tid, o_m_tlast, o_m_tdata};
        if (exp_q.size() == 0) begin
          check_val("extra_beat", obs, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("beat", obs, e);
        end
        beats_seen++;
        if (gap_exp != 0) begin
          if (!first_beat) check_val("beat_gap", 32'(cycle - prev_cyc), 32'(gap_exp));
          first_beat = 1'b0;
          prev_cyc   = cycle;
        end
      end
      @(posedge i_clk);
      cycle++;
      #1;
      if (took[0] && q0.size() > 0) void'(q0.pop_front());
      if (took[1] && q1.size() > 0) void'(q1.pop_front());
      if (took[2] && q2.size() > 0) void'(q2.pop_front());
      if (took[3] && q3.size() > 0) void'(q3.pop_front());
      i_s_tvalid[0] = (q0.size() != 0);
      i_s_tvalid[1] = (q1.size() != 0);
      i_s_tvalid[2] = (q2.size() != 0);
      i_s_tvalid[3] = (q3.size() != 0);
      {i_s_tlast[0], i_s_tdata[0*W +: W]} = (q0.size() != 0) ? q0[0] : 17'd0;
      {i_s_tlast[1], i_s_tdata[1*W +: W]} = (q1.size() != 0) ? q1[0] : 17'd0;
      {i_s_tlast[2], i_s_tdata[2*W +: W]} = (q2.size() != 0) ? q2[0] : 17'd0;
      {i_s_tlast[3], i_s_tdata[3*W +: W]} = (q3.size() != 0) ? q3[0] : 17'd0;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    i_aresetn  = 1'b0;
    i_m_tready = 1'b1;

    // ---------------- Reset values ----------------
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_val("rst_m_tvalid", 32'(o_m_tvalid), 32'd0);
    check_val("rst_s_tready", 32'(o_s_tready), 32'd0);
    check_val("rst_m_tdata",  32'(o_m_tdata),  32'd0);
    check_val("rst_m_tlast",  32'(o_m_tlast),  32'd0);
    check_val("rst_m_tid",    32'(o_m_tid),    32'd0);
    check_val("rst_busy",     32'(o_busy),     32'd0);
    @(posedge i_clk); #3 i_aresetn = 1'b1;
    repeat (2) @(posedge i_clk);

    // ---------------- 1: single requester + latency ----------------
    @(posedge i_clk); #2;
    push_both(2, 16'h00A1, 1'b0);
    push_both(2, 16'h00A2, 1'b0);
    push_both(2, 16'h00A3, 1'b1);
    gap_exp = 1; first_beat = 1'b1;
    @(posedge i_clk);                      // cycle 0: tvalid rises
    @(negedge i_clk);
    check_val("lat_c0_tready", 32'(o_s_tready), 32'd0);
    check_val("lat_c0_mvalid", 32'(o_m_tvalid), 32'd0);
    @(negedge i_clk);                      // cycle 1
    check_val("lat_c1_tready", 32'(o_s_tready), 32'b0100);
    check_val("lat_c1_mvalid", 32'(o_m_tvalid), 32'd0);
    check_val("lat_c1_busy",   32'(o_busy),     32'd1);
    @(negedge i_clk);                      // cycle 2
    check_val("lat_c2_mvalid", 32'(o_m_tvalid), 32'd1);
    wait_drain("t1_drain");
    gap_exp = 0;

    // ---------------- 5: pointer wrap (ptr now 3) ----------------
    @(posedge i_clk); #2;
    push_src(1, 16'h00B1, 1'b1);
    push_src(3, 16'h00B3, 1'b1);
    push_exp(3, 16'h00B3, 1'b1);
    push_exp(1, 16'h00B1, 1'b1);
    wait_drain("t5a_drain");
    // ptr should now be 2: requester 2 beats requester 0
    @(posedge i_clk); #2;
    push_src(0, 16'h00C0, 1'b1);
    push_src(2, 16'h00C2, 1'b1);
    push_exp(2, 16'h00C2, 1'b1);
    push_exp(0, 16'h00C0, 1'b1);
    wait_drain("t5b_drain");

    // ---------------- 4: backpressure (ptr now 1) ----------------
    @(posedge i_clk); #2;
    for (int i = 0; i < 6; i++) push_both(1, 16'h00D0 + 16'(i), (i == 5));
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (o_m_tvalid) break;
    end
    check_val("bp_start_valid", 32'(o_m_tvalid), 32'd1);
    @(posedge i_clk); #1 i_m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check_val("bp_tready", 32'(o_s_tready), 32'd0);
      check_val("bp_valid",  32'(o_m_tvalid), 32'd1);
      check_val("bp_hold", {13'd0, o_m_tid, o_m_tlast, o_m_tdata},
                (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
    end
    @(posedge i_clk); #1 i_m_tready = 1'b1;
    wait_drain("t4_drain");

    // ---------------- 6: reset mid-packet ----------------
    @(posedge i_clk); #2;
    for (int i = 0; i < 4; i++) push_both(1, 16'h00E0 + 16'(i), (i == 3));
    base = beats_seen;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (beats_seen > base) break;
    end
    check_val("mid_first_beat", 32'(beats_seen - base), 32'd1);
    @(posedge i_clk); #3;
    check_val("mid_pre_valid", 32'(o_m_tvalid), 32'd1);
    i_aresetn = 1'b0;
    #1;
    check_val("mid_m_tvalid", 32'(o_m_tvalid), 32'd0);
    check_val("mid_s_tready", 32'(o_s_tready), 32'd0);
    check_val("mid_m_tdata",  32'(o_m_tdata),  32'd0);
    check_val("mid_m_tlast",  32'(o_m_tlast),  32'd0);
    check_val("mid_m_tid",    32'(o_m_tid),    32'd0);
    check_val("mid_busy",     32'(o_busy),     32'd0);
    q0.delete(); q1.delete(); q2.delete(); q3.delete(); exp_q.delete();
    repeat (2) @(posedge i_clk);
    #3 i_aresetn = 1'b1;
    @(posedge i_clk); #2;
    push_both(0, 16'h00F0, 1'b1);
    wait_drain("t6_drain");

    // ---------------- 2: fairness after a clean reset ----------------
    @(posedge i_clk); #3 i_aresetn = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_aresetn = 1'b1;
    @(posedge i_clk); #2;
    push_src(0, 16'h0100, 1'b1); push_src(0, 16'h0104, 1'b1);
    push_src(1, 16'h0101, 1'b1); push_src(1, 16'h0105, 1'b1);
    push_src(2, 16'h0102, 1'b1);
    push_src(3, 16'h0103, 1'b1);
    push_exp(0, 16'h0100, 1'b1);
    push_exp(1, 16'h0101, 1'b1);
    push_exp(2, 16'h0102, 1'b1);
    push_exp(3, 16'h0103, 1'b1);
    push_exp(0, 16'h0104, 1'b1);
    push_exp(1, 16'h0105, 1'b1);
    gap_exp = 2; first_beat = 1'b1;
    wait_drain("t2_drain");
    gap_exp = 0;

    // ---------------- 3: packet lock (ptr now 2) ----------------
    @(posedge i_clk); #2;
    for (int i = 0; i < 4; i++) push_src(0, 16'h0200 + 16'(i), (i == 3));
    push_src(1, 16'h0210, 1'b1);
    push_src(1, 16'h0211, 1'b1);
    for (int i = 0; i < 4; i++) push_exp(0, 16'h0200 + 16'(i), (i == 3));
    push_exp(1, 16'h0210, 1'b1);
    push_exp(1, 16'h0211, 1'b1);
    wait_drain("t3_drain");

    repeat (3) @(posedge i_clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
